// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared sizes, FSM encoding and index helper for the memory port arbiter
package mem_port_arbiter_pkg;

   // Default block width shared by the caches and the block memory.
   localparam int MEMORY_BLOCK_SIZE = 128;

   // Default word address width of the block memory.
   localparam int DEFAULT_ADDR_W = 10;

   // Arbiter transaction states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_e;

   // Width of an index into n items; a single item still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational round-robin priority selector
module mem_port_arbiter_rr_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = idx_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             valid,
   output logic [PTR_W-1:0] grant
);

   int               idx;
   logic [PTR_W-1:0] sel;

   // Walk from the slot furthest behind ptr toward ptr so the last hit is the first requester at or after ptr.
   always_comb begin
      valid = 1'b0;
      grant = '0;
      idx   = 0;
      sel   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         sel = PTR_W'(idx);
         if (req[sel]) begin
            valid = 1'b1;
            grant = sel;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - N-channel round-robin arbiter from cache low-side ports to one block memory
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int BLK_W   = MEMORY_BLOCK_SIZE,
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_CH-1:0]       ch_req,
   input  logic [N_CH-1:0]       ch_wr,
   input  logic [N_CH*32-1:0]    ch_addr,
   input  logic [N_CH*BLK_W-1:0] ch_din,
   output logic [N_CH-1:0]       ch_rdy,
   output logic [N_CH-1:0]       ch_err,
   output logic [BLK_W-1:0]      ch_dout,
   output logic                  mem_req,
   output logic                  mem_wr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [BLK_W-1:0]      mem_din,
   input  logic [BLK_W-1:0]      mem_dout,
   input  logic                  mem_rdy
);

   localparam int PTR_W = idx_w(N_CH);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Last BUSY cycle index before the transaction is abandoned.
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   arb_state_e          state, state_d;
   logic [PTR_W-1:0]    g, g_d;
   logic [PTR_W-1:0]    rr_ptr, rr_ptr_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic                mem_req_d, mem_wr_d;
   logic [ADDR_W-1:0]   mem_addr_d;
   logic [BLK_W-1:0]    mem_din_d, ch_dout_d;
   logic [N_CH-1:0]     ch_rdy_d, ch_err_d;

   logic                pick_valid;
   logic [PTR_W-1:0]    pick_grant;
   int                  a_base;
   int                  d_base;

   // Only the low ADDR_W bits of each cache address reach the memory.
   logic                unused_addr_bits;
   assign unused_addr_bits = ^ch_addr;

   mem_port_arbiter_rr_pick #(
      .N     (N_CH),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req   (ch_req),
      .ptr   (rr_ptr),
      .valid (pick_valid),
      .grant (pick_grant)
   );

   // Next-state and next-output logic; every output is the registered copy of its _d value.
   always_comb begin
      state_d    = state;
      g_d        = g;
      rr_ptr_d   = rr_ptr;
      cnt_d      = cnt;
      mem_req_d  = mem_req;
      mem_wr_d   = mem_wr;
      mem_addr_d = mem_addr;
      mem_din_d  = mem_din;
      ch_dout_d  = ch_dout;
      ch_rdy_d   = '0;
      ch_err_d   = '0;
      a_base     = 32 * int'(pick_grant);
      d_base     = BLK_W * int'(pick_grant);

      case (state)
         ST_IDLE: begin
            if (pick_valid) begin
               g_d        = pick_grant;
               mem_wr_d   = ch_wr[pick_grant];
               mem_addr_d = ch_addr[a_base +: ADDR_W];
               mem_din_d  = ch_din[d_base +: BLK_W];
               mem_req_d  = 1'b1;
               cnt_d      = '0;
               state_d    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Channel inputs are deliberately not looked at here; the latched request owns the memory.
            if (mem_rdy) begin
               mem_req_d   = 1'b0;
               ch_rdy_d[g] = 1'b1;
               if (!mem_wr) begin
                  ch_dout_d = mem_dout;
               end
               state_d = ST_RESP;
            end else if ((TIMEOUT > 0) && (cnt == CNT_LAST)) begin
               mem_req_d   = 1'b0;
               ch_rdy_d[g] = 1'b1;
               ch_err_d[g] = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         ST_RESP: begin
            // ch_rdy is visible this cycle; advance priority past the channel just served.
            rr_ptr_d = (g == PTR_W'(N_CH - 1)) ? '0 : g + PTR_W'(1);
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         g        <= '0;
         rr_ptr   <= '0;
         cnt      <= '0;
         mem_req  <= 1'b0;
         mem_wr   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         ch_dout  <= '0;
         ch_rdy   <= '0;
         ch_err   <= '0;
      end else begin
         state    <= state_d;
         g        <= g_d;
         rr_ptr   <= rr_ptr_d;
         cnt      <= cnt_d;
         mem_req  <= mem_req_d;
         mem_wr   <= mem_wr_d;
         mem_addr <= mem_addr_d;
         mem_din  <= mem_din_d;
         ch_dout  <= ch_dout_d;
         ch_rdy   <= ch_rdy_d;
         ch_err   <= ch_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

   localparam int N  = 4;
   localparam int BW = 64;
   localparam int AW = 10;
   localparam int TO = 8;

   localparam logic [BW-1:0] DEAD  = 64'hDEAD_0123_4567_BEEF;
   localparam logic [BW-1:0] WDATA = 64'h1234_89AB_CDEF_5678;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    ch_req, ch_wr;
   logic [N*32-1:0] ch_addr;
   logic [N*BW-1:0] ch_din;
   logic [N-1:0]    ch_rdy, ch_err;
   logic [BW-1:0]   ch_dout;
   logic            mem_req, mem_wr;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_din, mem_dout;
   logic            mem_rdy;

   int n_vec = 0;
   int n_err = 0;

   logic [BW-1:0] mem_model [0:1023];
   logic [BW-1:0] ref_mem   [0:1023];
   bit            mem_en    = 1'b1;
   int            lat       = 0;
   int            lat_cnt   = 0;
   bit            resp_done = 1'b0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .N_CH    (N),
      .BLK_W   (BW),
      .ADDR_W  (AW),
      .TIMEOUT (TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ch_req   (ch_req),
      .ch_wr    (ch_wr),
      .ch_addr  (ch_addr),
      .ch_din   (ch_din),
      .ch_rdy   (ch_rdy),
      .ch_err   (ch_err),
      .ch_dout  (ch_dout),
      .mem_req  (mem_req),
      .mem_wr   (mem_wr),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .mem_rdy  (mem_rdy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One cycle: advance to the falling edge, then act as the block memory.
   task automatic tick();
      @(negedge clk);
      if (mem_rdy) begin
         mem_rdy = 1'b0;
      end else if (mem_req && mem_en && !resp_done) begin
         if (lat_cnt >= lat) begin
            mem_rdy   = 1'b1;
            resp_done = 1'b1;
            if (mem_wr) begin
               mem_model[mem_addr] = mem_din;
               mem_dout = {$urandom, $urandom};
            end else begin
               mem_dout = mem_model[mem_addr];
            end
         end else begin
            lat_cnt++;
         end
      end
      if (!mem_req) begin
         resp_done = 1'b0;
         lat_cnt   = 0;
      end
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      ch_req = '0; ch_wr = '0; ch_addr = '0; ch_din = '0;
      mem_rdy = 1'b0; mem_dout = '0; resp_done = 1'b0; lat_cnt = 0; mem_en = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         mem_model[i] = '0;
         ref_mem[i]   = '0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      tick();
   endtask

   task automatic do_txn(input int ch, input bit wr, input logic [31:0] addr, input logic [BW-1:0] data,
                         input int latency, input bit en,
                         output int busy, output logic [N-1:0] rdy, output logic [N-1:0] err,
                         output logic seen_wr, output logic [AW-1:0] seen_addr, output logic [BW-1:0] seen_din,
                         output int gap, output int t_done, output bit done);
      int rdy_at;
      lat = latency; mem_en = en;
      busy = 0; rdy = '0; err = '0; seen_wr = 1'b0; seen_addr = '0; seen_din = '0;
      gap = -1; t_done = -1; done = 1'b0; rdy_at = -100;
      ch_wr[ch] = wr;
      ch_addr[32*ch +: 32] = addr;
      ch_din[BW*ch +: BW] = data;
      ch_req[ch] = 1'b1;
      for (int t = 0; t < 60 && !done; t++) begin
         tick();
         if (mem_rdy) rdy_at = t;
         if (mem_req) begin
            busy++;
            seen_wr = mem_wr; seen_addr = mem_addr; seen_din = mem_din;
         end
         if (ch_rdy != '0) begin
            rdy = ch_rdy; err = ch_err; gap = t - rdy_at; t_done = t;
            ch_req[ch] = 1'b0;
            done = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      ch_req = '0; ch_wr = '0; ch_addr = '0; ch_din = '0; mem_rdy = 1'b0; mem_dout = '0;
      #1;
      n_vec++; if (ch_rdy !== '0)   begin n_err++; $display("FAIL reset_ch_rdy: got %h expected 0", ch_rdy); end
      n_vec++; if (ch_err !== '0)   begin n_err++; $display("FAIL reset_ch_err: got %h expected 0", ch_err); end
      n_vec++; if (ch_dout !== '0)  begin n_err++; $display("FAIL reset_ch_dout: got %h expected 0", ch_dout); end
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
      n_vec++; if ({mem_wr, mem_addr, mem_din} !== '0) begin
         n_err++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_wr, mem_addr, mem_din});
      end
      apply_reset();
   endtask

   task automatic test_single_read();
      int busy, gap, t_done; logic [N-1:0] rdy, err; logic sw; logic [AW-1:0] sa; logic [BW-1:0] sd; bit done;
      apply_reset();
      mem_model[4] = DEAD;
      do_txn(0, 1'b0, 32'h0000_0004, '0, 3, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      n_vec++; if (!done)          begin n_err++; $display("FAIL single_done: got %b expected 1", done); end
      n_vec++; if (busy != 4)      begin n_err++; $display("FAIL single_mem_req_cycles: got %0d expected 4", busy); end
      n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL single_ch_rdy: got %b expected 0001", rdy); end
      n_vec++; if (err !== 4'b0000) begin n_err++; $display("FAIL single_ch_err: got %b expected 0000", err); end
      n_vec++; if (gap != 1)       begin n_err++; $display("FAIL single_rdy_gap: got %0d expected 1", gap); end
      n_vec++; if (ch_dout !== DEAD) begin n_err++; $display("FAIL single_ch_dout: got %h expected %h", ch_dout, DEAD); end
      n_vec++; if ({sw, sa} !== {1'b0, 10'h004}) begin
         n_err++; $display("FAIL single_mem_cmd: got %h expected %h", {sw, sa}, {1'b0, 10'h004});
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] rearm;
      int k;
      apply_reset();
      lat = 1; mem_en = 1'b1; rearm = '0; k = 0;
      ch_wr = '0;
      ch_req[0] = 1'b1;
      ch_req[1] = 1'b1;
      for (int t = 0; t < 200 && k < 6; t++) begin
         tick();
         ch_req = ch_req | rearm;
         rearm  = '0;
         if (ch_rdy != '0) begin
            n_vec++;
            if (ch_rdy !== N'(1 << (k % 2))) begin
               n_err++; $display("FAIL alternate_grant_%0d: got %b expected %b", k, ch_rdy, N'(1 << (k % 2)));
            end
            ch_req = ch_req & ~ch_rdy;
            rearm  = ch_rdy;
            k++;
         end
      end
      n_vec++; if (k != 6) begin n_err++; $display("FAIL alternate_count: got %0d expected 6", k); end
      ch_req = '0;
      repeat (12) tick();
   endtask

   task automatic test_write_readback();
      int busy, gap, t_done; logic [N-1:0] rdy, err; logic sw; logic [AW-1:0] sa; logic [BW-1:0] sd; bit done;
      logic [BW-1:0] prev;
      apply_reset();
      mem_model[3] = DEAD;
      do_txn(0, 1'b0, 32'h0000_0003, '0, 1, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      tick();
      prev = ch_dout;
      do_txn(1, 1'b1, 32'hA5A5_0010, WDATA, 2, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      n_vec++; if ({sw, sa, sd} !== {1'b1, 10'h010, WDATA}) begin
         n_err++; $display("FAIL write_mem_cmd: got %h expected %h", {sw, sa, sd}, {1'b1, 10'h010, WDATA});
      end
      n_vec++; if (rdy !== 4'b0010) begin n_err++; $display("FAIL write_ch_rdy: got %b expected 0010", rdy); end
      n_vec++; if (ch_dout !== prev) begin n_err++; $display("FAIL write_keeps_dout: got %h expected %h", ch_dout, prev); end
      tick();
      do_txn(0, 1'b0, 32'h0000_0010, '0, 0, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      n_vec++; if (sw !== 1'b0)     begin n_err++; $display("FAIL readback_mem_wr: got %b expected 0", sw); end
      n_vec++; if (rdy !== 4'b0001) begin n_err++; $display("FAIL readback_ch_rdy: got %b expected 0001", rdy); end
      n_vec++; if (ch_dout !== WDATA) begin n_err++; $display("FAIL readback_data: got %h expected %h", ch_dout, WDATA); end
      n_vec++; if ({busy, t_done} != {32'd1, 32'd1}) begin
         n_err++; $display("FAIL zero_wait_latency: got busy %0d done %0d expected 1 1", busy, t_done);
      end
      tick();
   endtask

   task automatic test_timeout();
      int busy, gap, t_done; logic [N-1:0] rdy, err; logic sw; logic [AW-1:0] sa; logic [BW-1:0] sd; bit done;
      logic [BW-1:0] prev;
      prev = ch_dout;
      mem_model[5] = DEAD;
      do_txn(2, 1'b0, 32'h0000_0005, '0, 0, 1'b0, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      n_vec++; if (busy != TO)      begin n_err++; $display("FAIL timeout_busy_cycles: got %0d expected %0d", busy, TO); end
      n_vec++; if (rdy !== 4'b0100) begin n_err++; $display("FAIL timeout_ch_rdy: got %b expected 0100", rdy); end
      n_vec++; if (err !== 4'b0100) begin n_err++; $display("FAIL timeout_ch_err: got %b expected 0100", err); end
      n_vec++; if (ch_dout !== prev) begin n_err++; $display("FAIL timeout_keeps_dout: got %h expected %h", ch_dout, prev); end
      tick();
      do_txn(3, 1'b0, 32'h0000_0005, '0, 2, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      n_vec++; if ({rdy, err} !== {4'b1000, 4'b0000}) begin
         n_err++; $display("FAIL after_timeout_rdy_err: got %b expected 10000000", {rdy, err});
      end
      n_vec++; if (ch_dout !== DEAD) begin n_err++; $display("FAIL after_timeout_data: got %h expected %h", ch_dout, DEAD); end
      tick();
   endtask

   task automatic test_reset_mid();
      int busy, gap, t_done; logic [N-1:0] rdy, err; logic sw; logic [AW-1:0] sa; logic [BW-1:0] sd; bit done;
      logic [N-1:0] first;
      apply_reset();
      do_txn(0, 1'b0, 32'h0000_0001, '0, 0, 1'b1, busy, rdy, err, sw, sa, sd, gap, t_done, done);
      tick();
      mem_en = 1'b0;
      ch_wr[1] = 1'b0;
      ch_addr[63:32] = 32'h0000_0002;
      ch_req[1] = 1'b1;
      repeat (4) tick();
      #2;
      rst = 1'b0;
      ch_req = '0;
      #1;
      n_vec++; if ({mem_req, mem_wr, mem_addr, mem_din} !== '0) begin
         n_err++; $display("FAIL async_reset_mem: got %h expected 0", {mem_req, mem_wr, mem_addr, mem_din});
      end
      n_vec++; if ({ch_rdy, ch_err, ch_dout} !== '0) begin
         n_err++; $display("FAIL async_reset_ch: got %h expected 0", {ch_rdy, ch_err, ch_dout});
      end
      @(negedge clk);
      rst = 1'b1;
      mem_rdy = 1'b0;
      for (int i = 0; i < 1024; i++) mem_model[i] = '0;
      for (int t = 0; t < 3; t++) begin
         tick();
         n_vec++; if (ch_rdy !== '0) begin n_err++; $display("FAIL reset_no_rdy: got %b expected 0000", ch_rdy); end
      end
      mem_en = 1'b1; lat = 0;
      ch_req[0] = 1'b1;
      ch_req[1] = 1'b1;
      first = '0;
      for (int t = 0; t < 40 && ch_req != '0; t++) begin
         tick();
         if (ch_rdy != '0) begin
            if (first == '0) first = ch_rdy;
            ch_req = ch_req & ~ch_rdy;
         end
      end
      n_vec++; if (first !== 4'b0001) begin n_err++; $display("FAIL reset_ptr_grant: got %b expected 0001", first); end
      ch_req = '0;
      tick();
   endtask

   task automatic test_random();
      bit            pend [N];
      bit            just [N];
      logic          pwr  [N];
      logic [AW-1:0] paddr[N];
      logic [BW-1:0] pdata[N];
      int            waitn[N];
      int            rr_m, eg, cyc;
      bit            prev_req, any;
      logic [31:0]   a32;
      logic [BW-1:0] model_dout;
      apply_reset();
      for (int c = 0; c < N; c++) begin
         pend[c] = 1'b0; just[c] = 1'b0; pwr[c] = 1'b0; paddr[c] = '0; pdata[c] = '0; waitn[c] = 0;
      end
      rr_m = 0; eg = -1; prev_req = 1'b0; model_dout = '0;
      mem_en = 1'b1; lat = $urandom_range(0, 5);
      cyc = 0; any = 1'b1;
      while (cyc < 2300 && (cyc < 2000 || any)) begin
         tick();
         if (mem_req && !prev_req) begin
            eg = -1;
            for (int k = 0; k < N; k++) begin
               if (eg < 0 && ch_req[(rr_m + k) % N]) eg = (rr_m + k) % N;
            end
            n_vec++;
            if (eg < 0) begin
               n_err++; $display("FAIL rand_spurious_req: got mem_req 1 expected 0 (no requester)");
            end else if ({mem_wr, mem_addr, mem_din} !== {pwr[eg], paddr[eg], pdata[eg]}) begin
               n_err++; $display("FAIL rand_grant_cmd ch%0d: got %h expected %h", eg,
                                 {mem_wr, mem_addr, mem_din}, {pwr[eg], paddr[eg], pdata[eg]});
            end
         end
         prev_req = mem_req;
         if (ch_rdy != '0 || ch_err != '0) begin
            n_vec++;
            if (eg < 0 || ch_rdy !== N'(1 << eg) || ch_err !== '0) begin
               n_err++; $display("FAIL rand_rdy_route: got rdy %b err %b expected rdy on ch%0d", ch_rdy, ch_err, eg);
            end
            if (eg >= 0) begin
               n_vec++;
               if (!pwr[eg]) begin
                  model_dout = ref_mem[paddr[eg]];
                  if (ch_dout !== model_dout) begin
                     n_err++; $display("FAIL rand_read_data ch%0d: got %h expected %h", eg, ch_dout, model_dout);
                  end
               end else begin
                  ref_mem[paddr[eg]] = pdata[eg];
                  if (ch_dout !== model_dout) begin
                     n_err++; $display("FAIL rand_write_keeps_dout: got %h expected %h", ch_dout, model_dout);
                  end
               end
               n_vec++;
               if (waitn[eg] > N - 1) begin
                  n_err++; $display("FAIL rand_fairness ch%0d: got %0d waits expected at most %0d", eg, waitn[eg], N - 1);
               end
               for (int c = 0; c < N; c++) if (c != eg && pend[c]) waitn[c]++;
               pend[eg] = 1'b0; just[eg] = 1'b1; ch_req[eg] = 1'b0;
               rr_m = (eg + 1) % N;
               eg = -1;
               lat = $urandom_range(0, 5);
            end
         end
         any = 1'b0;
         for (int c = 0; c < N; c++) begin
            if (cyc < 2000 && !pend[c] && !just[c] && $urandom_range(0, 2) == 0) begin
               a32 = $urandom;
               a32[AW-1:0] = AW'($urandom_range(0, 15));
               pwr[c] = 1'($urandom_range(0, 1));
               paddr[c] = a32[AW-1:0];
               pdata[c] = {$urandom, $urandom};
               waitn[c] = 0;
               pend[c] = 1'b1;
               ch_wr[c] = pwr[c];
               ch_addr[32*c +: 32] = a32;
               ch_din[BW*c +: BW] = pdata[c];
               ch_req[c] = 1'b1;
            end
            just[c] = 1'b0;
            if (pend[c]) any = 1'b1;
         end
         cyc++;
      end
      n_vec++;
      if (any) begin n_err++; $display("FAIL rand_drain: got pending requests expected none"); end
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_simultaneous();
      test_write_readback();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised N-channel arbiter between multiple cache instances' low-side (Req_Low/Wr_Low/A_Low/DO_Low/DI_Low/Rdy_Low) ports and one shared block memory.
- Replaces the fixed one-cache-to-one-memory wiring at the top level, so multi-core or split I/D configurations share the memory model.
- Round-robin fair grant, one outstanding memory transaction, registered response routing, and a response timeout with error flag.

Parameters:
- N_CH, 2, number of cache channels (1..8).
- BLK_W, 128, memory block width in bits; equals the shared Memory_Block_Size.
- ADDR_W, 10, memory address width; mem_addr = A_Low[ADDR_W-1:0].
- TIMEOUT, 64, cycles to wait for mem_rdy before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ch_req  in  N_CH  per-channel request; held high until that channel's ch_rdy pulse.
- ch_wr  in  N_CH  per-channel write (1) / read (0).
- ch_addr  in  N_CH*32  per-channel A_Low; channel i at [32*i+31:32*i].
- ch_din  in  N_CH*BLK_W  per-channel write block (cache DO_Low).
- ch_rdy  out  N_CH  one-cycle completion pulse to the granted channel (cache Rdy_Low).
- ch_err  out  N_CH  one-cycle pulse coincident with ch_rdy when the transaction timed out.
- ch_dout  out  BLK_W  read block shared by all channels (cache DI_Low); valid when that channel's ch_rdy is high.
- mem_req  out  1  memory request.
- mem_wr  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_din  out  BLK_W  memory write data.
- mem_dout  in  BLK_W  memory read data.
- mem_rdy  in  1  memory completion pulse.

Behaviour:
- Reset (rst low, asynchronous): all outputs 0, state IDLE, rr_ptr=0, timeout counter 0. Assertion mid-transaction aborts immediately with no ch_rdy. Memory must also be reset.
- Every output is registered.
- FSM IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - If any ch_req is high, pick the first requesting channel at or after rr_ptr, wrapping modulo N_CH.
  - Latch grant index g, ch_wr[g], ch_addr[g][ADDR_W-1:0] and ch_din[g] into mem_wr/mem_addr/mem_din.
  - Set mem_req=1 and go to BUSY. mem_req rises the cycle after ch_req is first sampled.
- BUSY:
  - mem_req stays high and mem_* stay stable.
  - Changes on ch_* inputs are ignored, including the granted channel dropping its req.
  - On mem_rdy: mem_req=0. For a read, register mem_dout into ch_dout. Go to RESP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT-1 without mem_rdy: mem_req=0, set an error flag, go to RESP. ch_dout is unchanged.
- RESP (exactly one cycle):
  - ch_rdy[g]=1; ch_err[g]=error flag.
  - rr_ptr=(g+1) mod N_CH.
  - Go to IDLE. mem_req is low for at least this cycle.
- Latency: ch_rdy pulses the cycle after mem_rdy. A zero-wait memory (mem_rdy in the first BUSY cycle) gives 3 cycles from ch_req sampled to ch_rdy.
- The requester drops ch_req in the cycle it sees ch_rdy. IDLE re-samples the next cycle, so there is no double service.
- ch_dout holds its value between reads. Writes never modify it.
- A mem_rdy arriving outside BUSY is ignored.
- No request is lost. A requester waits at most N_CH-1 other transactions.
- Counter width is clog2(TIMEOUT+1). The counter clears on entry to BUSY.

Decomposition:
- Shared package/include (alongside data_def.v): Memory_Block_Size, default memory address width, FSM state encodings (IDLE=2'd0, BUSY=2'd1, RESP=2'd2).
- One sub-module, rr_pick: combinational round-robin priority selector. Inputs are the req vector and ptr. Outputs are a valid flag and the grant index. Reusable for future multi-master buses.
- Top-level integration instantiates N_CH cache instances feeding this block, and this block feeds the single memory.

Test Plan:
- Single read, N_CH=2, ch0 reads addr 0x004, memory returns 0xDEAD...BEEF after 3 cycles → mem_req high 4 cycles, ch_rdy[0] one pulse the cycle after mem_rdy, ch_dout=0xDEAD...BEEF, ch_err=0.
- Simultaneous requests, ch0 and ch1 raised in the same cycle with rr_ptr=0 → ch0 served first, then ch1. Repeat with both held continuously → grants strictly alternate 0,1,0,1.
- Write then read back, ch1 writes block 0x1234...5678 to addr 0x010, then ch0 reads 0x010 → mem_wr=1 only in the first transaction, ch_dout unchanged after the write, and the read returns 0x1234...5678.
- Timeout, TIMEOUT=8, memory never asserts mem_rdy → mem_req drops after 8 BUSY cycles, ch_rdy[g] and ch_err[g] pulse together, ch_dout unchanged, next request serviced normally.
- Reset mid-BUSY, rst low for 1 cycle during a ch1 read → all outputs 0 asynchronously, no ch_rdy, rr_ptr=0. Next simultaneous request grants ch0.
- Scale, N_CH=4, BLK_W=64, random requests on all channels for 2000 cycles → scoreboard matches the reference memory, no channel waits more than 3 transactions, and no ch_rdy pulse on a non-granted channel.
